// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: board constants shared by the input conditioning blocks
package input_conditioner_pkg;

    localparam int DEFAULT_WIDTH           = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: synchronizer, stability counter, debounced level and edge pulses for one input bit
module debounce_bit
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall,
    output logic o_rise_set
);

    localparam int              CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s0;
    logic          r_s1;
    logic          r_stable;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_cnt;
    logic          w_differ;
    logic          w_toggle;

    assign w_differ   = r_s1 != r_stable;
    assign w_toggle   = w_differ && (r_cnt == LAST);
    assign o_rise_set = w_toggle & r_s1;
    assign o_stable   = r_stable;
    assign o_rise     = r_rise;
    assign o_fall     = r_fall;

    // two-flop synchronizer for the asynchronous board input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
        end else begin
            r_s0 <= i_raw;
            r_s1 <= r_s0;
        end
    end

    // any cycle matching the current level restarts the window; a full window commits the new level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_cnt    <= (!w_differ || w_toggle) ? '0 : r_cnt + 1'b1;
            r_stable <= w_toggle ? r_s1 : r_stable;
            r_rise   <= w_toggle & r_s1;
            r_fall   <= w_toggle & ~r_s1;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: per-bit debounce of board inputs with edge pulses and sticky rise events
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rawPorts,
    input  logic [WIDTH-1:0] clearEvents,
    output logic [WIDTH-1:0] cleanPorts,
    output logic [WIDTH-1:0] risePulse,
    output logic [WIDTH-1:0] fallPulse,
    output logic [WIDTH-1:0] eventLatch
);

    logic [WIDTH-1:0] w_rise_set;
    logic [WIDTH-1:0] r_event;

    assign eventLatch = r_event;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk       (clk),
            .rst       (rst),
            .i_raw     (rawPorts[g]),
            .o_stable  (cleanPorts[g]),
            .o_rise    (risePulse[g]),
            .o_fall    (fallPulse[g]),
            .o_rise_set(w_rise_set[g])
        );
    end

    // sticky event flags: a rise registered on the same edge as a clear keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_event <= '0;
        end else begin
            r_event <= (r_event & ~clearEvents) | w_rise_set;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: randomized and directed scoreboard bench against a run-length reference model
module tb_input_conditioner;

    localparam int W  = 2;
    localparam int DC = 4;

    typedef struct packed {
        logic [W-1:0] clean;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] latch;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] rawPorts = '0;
    logic [W-1:0] clearEvents = '0;
    logic [W-1:0] cleanPorts;
    logic [W-1:0] risePulse;
    logic [W-1:0] fallPulse;
    logic [W-1:0] eventLatch;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [W-1:0] m_d1, m_d2, m_stable, m_rise, m_fall, m_latch;
    int           m_run[W];

    input_conditioner #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rawPorts   (rawPorts),
        .clearEvents(clearEvents),
        .cleanPorts (cleanPorts),
        .risePulse  (risePulse),
        .fallPulse  (fallPulse),
        .eventLatch (eventLatch)
    );

    always #5 clk = ~clk;

    // reference: input seen two edges late; level commits after DC consecutive edges of disagreement
    task automatic model_edge(input logic [W-1:0] raw, input logic [W-1:0] clr, input logic r);
        if (r) begin
            m_d1 = '0; m_d2 = '0; m_stable = '0; m_rise = '0; m_fall = '0; m_latch = '0;
            for (int b = 0; b < W; b++) m_run[b] = 0;
        end else begin
            for (int b = 0; b < W; b++) begin
                m_rise[b] = 1'b0;
                m_fall[b] = 1'b0;
                if (m_d2[b] != m_stable[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DC) begin
                        m_stable[b] = m_d2[b];
                        m_rise[b]   = m_d2[b];
                        m_fall[b]   = ~m_d2[b];
                        m_run[b]    = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_latch[b] = m_rise[b] | (m_latch[b] & ~clr[b]);
            end
            m_d2 = m_d1;
            m_d1 = raw;
        end
    endtask

    task automatic step(input logic [W-1:0] raw, input logic [W-1:0] clr, input logic r);
        @(negedge clk);
        rawPorts    = raw;
        clearEvents = clr;
        rst         = r;
        model_edge(raw, clr, r);
        q.push_back('{clean: m_stable, rise: m_rise, fall: m_fall, latch: m_latch});
    endtask

    task automatic hold(input logic [W-1:0] raw, input int n);
        for (int i = 0; i < n; i++) step(raw, '0, 1'b0);
    endtask

    // monitor: after every edge, compare the DUT outputs against the oldest pending expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_cmp++;
                if (cleanPorts !== e.clean || risePulse !== e.rise ||
                    fallPulse !== e.fall || eventLatch !== e.latch) begin
                    n_bad++;
                    $display("FAIL outputs t=%0t got clean=%b rise=%b fall=%b latch=%b expected clean=%b rise=%b fall=%b latch=%b",
                             $time, cleanPorts, risePulse, fallPulse, eventLatch,
                             e.clean, e.rise, e.fall, e.latch);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] raw;
        for (int b = 0; b < W; b++) m_run[b] = 0;
        for (int i = 0; i < 3; i++) step('0, '1, 1'b1);
        hold(2'b00, 20);
        hold(2'b01, 10);
        step(2'b11, '0, 1'b0);
        step(2'b01, '0, 1'b0);
        step(2'b11, '0, 1'b0);
        step(2'b01, '0, 1'b0);
        hold(2'b11, 10);
        hold(2'b10, 10);
        hold(2'b11, 3);
        hold(2'b10, 10);
        hold(2'b11, 5);
        step(2'b11, 2'b01, 1'b0);
        hold(2'b11, 4);
        step(2'b11, 2'b01, 1'b0);
        hold(2'b11, 3);
        hold(2'b00, 10);
        hold(2'b01, 5);
        step(2'b01, '0, 1'b1);
        step(2'b01, '0, 1'b1);
        hold(2'b01, 10);
        raw = 2'b01;
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 5) == 0) raw[b] = ~raw[b];
            step(raw, ($urandom_range(0, 5) == 0) ? W'($urandom) : '0, $urandom_range(0, 200) == 0);
        end
        hold(raw, 10);
        @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter WIDTH, default 2, number of independent input bits (matches microprocessor inputPorts width).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stability window in clk cycles; legal range >= 1.
REQ-003 SHALL have port clk, input, 1, single clock for all state.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset, sampled on rising clk edge.
REQ-005 SHALL have port rawPorts, input, WIDTH, asynchronous bouncing board inputs (switches/buttons).
REQ-006 SHALL have port clearEvents, input, WIDTH, per-bit clear of eventLatch.
REQ-007 SHALL have port cleanPorts, output, WIDTH, debounced level; drives microprocessor inputPorts.
REQ-008 SHALL have port risePulse, output, WIDTH, one-cycle pulse on debounced 0->1.
REQ-009 SHALL have port fallPulse, output, WIDTH, one-cycle pulse on debounced 1->0.
REQ-010 SHALL have port eventLatch, output, WIDTH, sticky per-bit flag set by rise, held until cleared.

Function
REQ-011 SHALL pass each rawPorts bit through a 2-flop synchronizer (s0, s1); only s1 feeds further logic.
REQ-012 SHALL keep per bit a counter of width clog2(DEBOUNCE_CYCLES+1) and a stable register driving cleanPorts.
REQ-013 SHALL, per edge: if s1 == stable, clear counter to 0; else if counter == DEBOUNCE_CYCLES-1, load stable <= s1 and clear counter; else increment counter.
REQ-014 SHALL yield latency: raw change sampled at edge k, held steady, appears on cleanPorts after edge k+1+DEBOUNCE_CYCLES.
REQ-015 SHALL reject any glitch: a single cycle with s1 == stable restarts the window from 0; counter never wraps.
REQ-016 SHALL assert risePulse/fallPulse for exactly the one cycle after the edge at which stable toggles; registered outputs, never both in one cycle for a bit.
REQ-017 SHALL set eventLatch bit on the edge its rise toggle is registered; clear on edge with clearEvents bit high; simultaneous set and clear -> set wins.
REQ-018 SHALL treat all WIDTH bits fully independently (no shared counter).
REQ-019 SHALL hold all outputs steady between toggles; no combinational path rawPorts -> outputs.

Reset
REQ-020 SHALL, while rst high at edge, clear s0, s1, stable, counters, risePulse, fallPulse, eventLatch to 0.
REQ-021 SHALL abandon any in-progress debounce window on reset; after release, a raw input held at 1 produces cleanPorts=1 and one risePulse after DEBOUNCE_CYCLES+2 edges.
REQ-022 SHALL ignore clearEvents and rawPorts during reset.

Structure
REQ-023 SHALL place DEBOUNCE_CYCLES default and WIDTH default in the shared project package (board constants), not in the module.
REQ-024 SHALL use one sub-module, debounce_bit (sync + counter + stable + edge pulses for one bit), instantiated WIDTH times via generate; eventLatch logic in the top.
REQ-025 SHALL be instantiated in the board top, with cleanPorts driving microprocessor inputPorts.

Verification (DEBOUNCE_CYCLES=4, WIDTH=2 in bench)
REQ-026 SHALL check: reset, rawPorts=2'b00 -> all outputs 0 for 20 cycles.
REQ-027 SHALL check: rawPorts[0] 0->1 at edge k, held -> cleanPorts[0]=1 after edge k+5, risePulse[0] high exactly one cycle, eventLatch[0]=1 thereafter.
REQ-028 SHALL check: rawPorts[1] bounces 1,0,1,0 at 1-cycle intervals then holds 1 -> no pulse until 4 stable s1 cycles; exactly one risePulse[1].
REQ-029 SHALL check: 3-cycle high glitch on rawPorts[0] -> cleanPorts[0] stays 0, no pulses.
REQ-030 SHALL check: clearEvents[0]=1 on the same edge a new rise is registered -> eventLatch[0] remains 1; clearEvents alone -> 0 next cycle.
REQ-031 SHALL check: rst asserted with counter at 3 -> counter and outputs 0; held raw 1 yields risePulse exactly 6 edges after release.
